i2c_pad_conditioner: RTL and testbench
======================================

I2C_PAD_CONDITIONER -- requirements
Module: i2c_pad_conditioner

Interface
REQ-001 SHALL have parameter CHANNELS, default 2, giving the number of independent I2C buses.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, giving the depth of the pad-input synchroniser (minimum 2).
REQ-003 SHALL have parameter FILTER_LEN, default 4, giving the number of consecutive stable samples needed to accept a level (minimum 1).
REQ-004 SHALL have parameter TIMEOUT_W, default 16, giving the width of the stuck-SCL counter.
REQ-005 SHALL have parameter CLR_HALF, default 8, giving the bus-clear half-period in clocks (minimum 2).
REQ-006 SHALL have port wb_clk_i, input, 1 bit: the single clock.
REQ-007 SHALL have port wb_rst_i, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have ports core_scl_o, core_scl_oen, core_sda_o and core_sda_oen, inputs, CHANNELS bits each: master drive value and drive enable.
REQ-009 SHALL have ports core_scl_i and core_sda_i, outputs, CHANNELS bits each: filtered bus levels returned to the masters.
REQ-010 SHALL have ports pad_scl_i and pad_sda_i, inputs, CHANNELS bits each: raw pad levels.
REQ-011 SHALL have ports pad_scl_o, pad_scl_oeb, pad_sda_o and pad_sda_oeb, outputs, CHANNELS bits each: pad value and active-low output enable.
REQ-012 SHALL have port timeout_lim, input, TIMEOUT_W bits: stuck-SCL threshold, where 0 disables detection.
REQ-013 SHALL have port clr_req, input, CHANNELS bits: per-channel single-cycle request to start a bus clear.
REQ-014 SHALL have ports stuck_irq and clr_busy, outputs, CHANNELS bits each; and port clr_done, output, CHANNELS bits: single-cycle completion pulse.

Function
REQ-015 SHALL give every channel its own identical, fully independent logic.
REQ-016 SHALL drive pad_*_o to constant 0 (true open drain).
REQ-017 SHALL, outside bus clear, drive pad_x_oeb = ~(core_x_oen & ~core_x_o) as registered-free combinational logic.
REQ-018 SHALL pass each pad input through SYNC_STAGES flops, then a glitch filter.
REQ-019 SHALL make the filter output take a new level only after FILTER_LEN consecutive synchronised samples of that level.
REQ-020 SHALL, for a stable pad change, update core_*_i exactly SYNC_STAGES+FILTER_LEN rising edges after the change.
REQ-021 SHALL fully reject any synchronised pulse shorter than FILTER_LEN cycles.
REQ-022 SHALL implement the stuck counter as follows: increments each cycle filtered SCL=0, saturates at all-ones, clears to 0 when filtered SCL=1.
REQ-023 SHALL set stuck_irq (sticky) on the cycle the counter equals timeout_lim with timeout_lim≠0; it SHALL clear only when a bus clear starts.
REQ-024 SHALL implement the bus-clear FSM with states IDLE, PULSE_LOW, PULSE_HIGH, STOP_LOW, STOP_SCL, STOP_SDA and DONE.
REQ-025 SHALL, on clr_req in IDLE, go to PULSE_LOW, zero the pulse counter and clear stuck_irq; clr_req in any other state SHALL be ignored.
REQ-026 SHALL, while not IDLE, ignore core_* inputs and drive the pads only per FSM state.
REQ-027 SHALL, in PULSE_LOW, hold SCL low and SDA released for CLR_HALF cycles, then go to PULSE_HIGH.
REQ-028 SHALL, in PULSE_HIGH, release SCL for CLR_HALF cycles and increment the pulse count.
REQ-029 SHALL, at the end of PULSE_HIGH, go to STOP_LOW if filtered SDA=1 or the count equals 9; otherwise it SHALL return to PULSE_LOW.
REQ-030 SHALL, in STOP_LOW, drive SCL and SDA low; in STOP_SCL, release SCL with SDA low; in STOP_SDA, release both; each state SHALL last CLR_HALF cycles.
REQ-031 SHALL assert clr_done for one cycle in DONE, then return to IDLE.
REQ-032 SHALL make clr_busy = (state ≠ IDLE).
REQ-033 SHALL continue to update the filters and core_*_i during a bus clear.

Reset
REQ-034 SHALL, on wb_rst_i, asynchronously set sync flops and filter outputs to 1, counters to 0 and FSM to IDLE; stuck_irq, clr_busy and clr_done SHALL be 0.
REQ-035 SHALL, with wb_rst_i asserted mid-operation, release the pads immediately (oeb=1 regardless of core_*_oen), and any clear in progress SHALL be abandoned without a clr_done pulse.

Verification
REQ-036 SHALL cover the glitch filter: pad_sda_i[0] low 3 cycles -> core_sda_i[0] stays 1; low 4 cycles -> falls exactly 6 edges after the pad edge (defaults).
REQ-037 SHALL cover drive conversion: core_scl_oen=1, core_scl_o=0 -> pad_scl_oeb=0, pad_scl_o=0; core_scl_o=1 or core_scl_oen=0 -> pad_scl_oeb=1.
REQ-038 SHALL cover stuck detection: timeout_lim=100, pad_scl_i[1] held 0 -> stuck_irq[1] rises 106 edges after the pad edge; stuck_irq[0] stays 0; timeout_lim=0 -> never rises.
REQ-039 SHALL cover an early-exit clear: pad_sda_i held 0 until the 3rd PULSE_HIGH -> exactly 3 SCL pulses, then STOP, then one clr_done cycle; total busy equals 3*16+3*8+1 cycles.
REQ-040 SHALL cover a full clear: SDA never released -> exactly 9 SCL pulses then the STOP sequence; a second clr_req while busy has no effect.
REQ-041 SHALL cover reset mid-clear: wb_rst_i asserted in PULSE_LOW -> all oeb=1 within the same cycle, clr_busy=0, no clr_done pulse.

Source files
------------

// File: rtl/i2c_pad_conditioner.sv
// I2C pad conditioner: open-drain pad drive, synchronised and glitch-filtered
// pad inputs, stuck-SCL detection and a per-channel bus-clear sequencer.

// Pad-input synchroniser followed by a consecutive-sample glitch filter.
module i2c_glitch_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic pad_i,
    output logic level_o
);

    localparam int CW = $clog2(FILTER_LEN + 1);
    localparam logic [CW-1:0] FLT_LAST = CW'(FILTER_LEN - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q;
    logic                   level_q;
    logic                   sync_out;

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign level_o  = level_q;

    // Shift the pad through the synchroniser; accept a new level once it has
    // been seen FILTER_LEN times in a row, any interruption restarts the run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '1;
            cnt_q   <= '0;
            level_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pad_i};
            if (sync_out != level_q) begin
                if (cnt_q == FLT_LAST) begin
                    level_q <= sync_out;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

endmodule

module i2c_pad_conditioner #(
    parameter int CHANNELS    = 2,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4,
    parameter int TIMEOUT_W   = 16,
    parameter int CLR_HALF    = 8
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic [CHANNELS-1:0]  core_scl_o,
    input  logic [CHANNELS-1:0]  core_scl_oen,
    input  logic [CHANNELS-1:0]  core_sda_o,
    input  logic [CHANNELS-1:0]  core_sda_oen,
    output logic [CHANNELS-1:0]  core_scl_i,
    output logic [CHANNELS-1:0]  core_sda_i,
    input  logic [CHANNELS-1:0]  pad_scl_i,
    input  logic [CHANNELS-1:0]  pad_sda_i,
    output logic [CHANNELS-1:0]  pad_scl_o,
    output logic [CHANNELS-1:0]  pad_scl_oeb,
    output logic [CHANNELS-1:0]  pad_sda_o,
    output logic [CHANNELS-1:0]  pad_sda_oeb,
    input  logic [TIMEOUT_W-1:0] timeout_lim,
    input  logic [CHANNELS-1:0]  clr_req,
    output logic [CHANNELS-1:0]  stuck_irq,
    output logic [CHANNELS-1:0]  clr_busy,
    output logic [CHANNELS-1:0]  clr_done
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PULSE_LOW,
        ST_PULSE_HIGH,
        ST_STOP_LOW,
        ST_STOP_SCL,
        ST_STOP_SDA,
        ST_DONE
    } clr_state_t;

    localparam int HW = $clog2(CLR_HALF);
    localparam logic [HW-1:0] HALF_LAST = HW'(CLR_HALF - 1);

    assign pad_scl_o = '0;
    assign pad_sda_o = '0;

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
        logic                 scl_filt;
        logic                 sda_filt;
        logic [TIMEOUT_W-1:0] stuck_cnt_q;
        logic [TIMEOUT_W-1:0] stuck_cnt_nxt;
        logic                 irq_q;
        clr_state_t           state_q;
        logic [HW-1:0]        half_q;
        logic [3:0]           pulse_q;
        logic                 half_end;
        logic                 clr_start;
        logic                 scl_low;
        logic                 sda_low;

        i2c_glitch_filter #(
            .SYNC_STAGES(SYNC_STAGES),
            .FILTER_LEN (FILTER_LEN)
        ) u_scl_flt (
            .clk    (wb_clk_i),
            .rst    (wb_rst_i),
            .pad_i  (pad_scl_i[ch]),
            .level_o(scl_filt)
        );

        i2c_glitch_filter #(
            .SYNC_STAGES(SYNC_STAGES),
            .FILTER_LEN (FILTER_LEN)
        ) u_sda_flt (
            .clk    (wb_clk_i),
            .rst    (wb_rst_i),
            .pad_i  (pad_sda_i[ch]),
            .level_o(sda_filt)
        );

        assign core_scl_i[ch] = scl_filt;
        assign core_sda_i[ch] = sda_filt;
        assign half_end       = (half_q == HALF_LAST);
        assign clr_start      = clr_req[ch] && (state_q == ST_IDLE);

        // Next stuck-count value: saturating count of cycles with SCL low.
        always_comb begin
            stuck_cnt_nxt = stuck_cnt_q;
            if (scl_filt) begin
                stuck_cnt_nxt = '0;
            end else if (!(&stuck_cnt_q)) begin
                stuck_cnt_nxt = stuck_cnt_q + TIMEOUT_W'(1);
            end
        end

        // Stuck counter and sticky interrupt; the compare uses the incoming
        // count so the flag rises on the same edge the count reaches the limit.
        always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
            if (wb_rst_i) begin
                stuck_cnt_q <= '0;
                irq_q       <= 1'b0;
            end else begin
                stuck_cnt_q <= stuck_cnt_nxt;
                if (clr_start) begin
                    irq_q <= 1'b0;
                end else if ((timeout_lim != '0) && (stuck_cnt_nxt == timeout_lim)) begin
                    irq_q <= 1'b1;
                end
            end
        end

        // Bus-clear sequencer: up to nine SCL pulses, then a STOP condition.
        always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
            if (wb_rst_i) begin
                state_q <= ST_IDLE;
                half_q  <= '0;
                pulse_q <= '0;
            end else begin
                half_q <= half_end ? '0 : half_q + HW'(1);
                case (state_q)
                    ST_IDLE: begin
                        half_q <= '0;
                        if (clr_req[ch]) begin
                            state_q <= ST_PULSE_LOW;
                            pulse_q <= '0;
                        end
                    end
                    ST_PULSE_LOW: if (half_end) state_q <= ST_PULSE_HIGH;
                    ST_PULSE_HIGH: begin
                        if (half_end) begin
                            // pulse_q still holds the pre-increment count here
                            pulse_q <= pulse_q + 4'd1;
                            state_q <= (sda_filt || pulse_q == 4'd8) ? ST_STOP_LOW
                                                                     : ST_PULSE_LOW;
                        end
                    end
                    ST_STOP_LOW: if (half_end) state_q <= ST_STOP_SCL;
                    ST_STOP_SCL: if (half_end) state_q <= ST_STOP_SDA;
                    ST_STOP_SDA: if (half_end) state_q <= ST_DONE;
                    ST_DONE: begin
                        half_q  <= '0;
                        state_q <= ST_IDLE;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end

        // Pad pull-down selection: masters in IDLE, the sequencer otherwise.
        always_comb begin
            scl_low = 1'b0;
            sda_low = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    scl_low = core_scl_oen[ch] & ~core_scl_o[ch];
                    sda_low = core_sda_oen[ch] & ~core_sda_o[ch];
                end
                ST_PULSE_LOW: scl_low = 1'b1;
                ST_STOP_LOW: begin
                    scl_low = 1'b1;
                    sda_low = 1'b1;
                end
                ST_STOP_SCL: sda_low = 1'b1;
                default: begin
                    scl_low = 1'b0;
                    sda_low = 1'b0;
                end
            endcase
        end

        // Reset releases the pads combinationally, ahead of the state flops.
        assign pad_scl_oeb[ch] = wb_rst_i | ~scl_low;
        assign pad_sda_oeb[ch] = wb_rst_i | ~sda_low;
        assign stuck_irq[ch]   = irq_q;
        assign clr_busy[ch]    = (state_q != ST_IDLE);
        assign clr_done[ch]    = (state_q == ST_DONE);
    end

endmodule

// File: tb/tb_i2c_pad_conditioner.sv
// Directed self-checking bench for i2c_pad_conditioner with default parameters.
module tb_i2c_pad_conditioner;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  core_scl_o, core_scl_oen, core_sda_o, core_sda_oen;
    logic [1:0]  core_scl_i, core_sda_i;
    logic [1:0]  pad_scl_i, pad_sda_i;
    logic [1:0]  pad_scl_o, pad_scl_oeb, pad_sda_o, pad_sda_oeb;
    logic [15:0] timeout_lim;
    logic [1:0]  clr_req, stuck_irq, clr_busy, clr_done;

    int n_checks = 0;
    int n_pass   = 0;

    i2c_pad_conditioner #(
        .CHANNELS   (2),
        .SYNC_STAGES(2),
        .FILTER_LEN (4),
        .TIMEOUT_W  (16),
        .CLR_HALF   (8)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .core_scl_o  (core_scl_o),
        .core_scl_oen(core_scl_oen),
        .core_sda_o  (core_sda_o),
        .core_sda_oen(core_sda_oen),
        .core_scl_i  (core_scl_i),
        .core_sda_i  (core_sda_i),
        .pad_scl_i   (pad_scl_i),
        .pad_sda_i   (pad_sda_i),
        .pad_scl_o   (pad_scl_o),
        .pad_scl_oeb (pad_scl_oeb),
        .pad_sda_o   (pad_sda_o),
        .pad_sda_oeb (pad_sda_oeb),
        .timeout_lim (timeout_lim),
        .clr_req     (clr_req),
        .stuck_irq   (stuck_irq),
        .clr_busy    (clr_busy),
        .clr_done    (clr_done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Runs one bus clear on channel ch, starting at the next edge, and measures it.
    task automatic run_clear(input int ch, input int rel_pulse, input int req2_at,
                             output int pulses, output int busy_cyc, output int done_cyc,
                             output int stop_lo, output int stop_scl, output int other_busy,
                             output int ok_end);
        logic prev_scl, scl, sda, started;
        pulses = 0; busy_cyc = 0; done_cyc = 0; stop_lo = 0; stop_scl = 0;
        other_busy = 0; ok_end = 0; prev_scl = 1'b1; started = 1'b0;
        clr_req[ch] = 1'b1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(posedge clk);
            #1;
            clr_req = '0;
            scl = pad_scl_oeb[ch];
            sda = pad_sda_oeb[ch];
            if (clr_busy[1-ch]) other_busy++;
            if (clr_done[ch]) done_cyc++;
            if (clr_busy[ch]) begin
                busy_cyc++;
                started = 1'b1;
                if (!scl && sda && prev_scl) pulses++;
                if (!scl && !sda) stop_lo++;
                if (scl && !sda) stop_scl++;
                if (scl && !prev_scl && sda && pulses == rel_pulse && stop_lo == 0)
                    pad_sda_i[ch] = 1'b1;
                if (busy_cyc == req2_at) begin
                    clr_req[ch]      = 1'b1;
                    core_sda_oen[ch] = 1'b1;
                    core_sda_o[ch]   = 1'b0;
                end
            end
            prev_scl = scl;
            if (started && !clr_busy[ch]) begin
                ok_end = 1;
                break;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int first, seen_low, pulses, busy_cyc, done_cyc, stop_lo, stop_scl, other, ok_end;
        int dcount, bcount;

        rst = 1'b1;
        core_scl_o = '1; core_sda_o = '1; core_scl_oen = '0; core_sda_oen = 2'b01;
        core_sda_o = 2'b00;
        pad_scl_i = '1; pad_sda_i = '1; timeout_lim = '0; clr_req = '0;
        #23;
        // Reset state: core sda 0 drives low but reset keeps the pad released.
        check_eq("rst_pad_sda_oeb", pad_sda_oeb, 2'b11);
        check_eq("rst_core_scl_i", core_scl_i, 2'b11);
        check_eq("rst_core_sda_i", core_sda_i, 2'b11);
        check_eq("rst_stuck_irq", stuck_irq, 2'b00);
        check_eq("rst_busy", clr_busy, 2'b00);
        check_eq("rst_done", clr_done, 2'b00);
        rst = 1'b0;
        core_sda_oen = '0; core_sda_o = '1;
        tick(2);

        // Drive conversion.
        core_scl_oen = 2'b01; core_scl_o = 2'b00; #1;
        check_eq("drv_scl_oeb_low", pad_scl_oeb, 2'b10);
        check_eq("drv_scl_o", pad_scl_o, 2'b00);
        core_scl_o = 2'b01; #1;
        check_eq("drv_scl_o_high", pad_scl_oeb, 2'b11);
        core_scl_oen = 2'b00; core_scl_o = 2'b00; #1;
        check_eq("drv_scl_oen_off", pad_scl_oeb, 2'b11);
        core_sda_oen = 2'b10; core_sda_o = 2'b00; #1;
        check_eq("drv_sda_oeb", pad_sda_oeb, 2'b01);
        check_eq("drv_sda_o", pad_sda_o, 2'b00);
        core_sda_oen = '0; core_sda_o = '1; core_scl_o = '1;
        tick(1);

        // Three-cycle glitch must be rejected.
        pad_sda_i[0] = 1'b0;
        tick(3);
        pad_sda_i[0] = 1'b1;
        seen_low = 0;
        for (int k = 0; k < 12; k++) begin
            tick(1);
            if (!core_sda_i[0]) seen_low++;
        end
        check_eq("glitch3_rejected", seen_low, 0);

        // Four-cycle low is accepted exactly six edges after the pad edge.
        pad_sda_i[0] = 1'b0;
        first = 0;
        for (int k = 1; k <= 10; k++) begin
            tick(1);
            if (k == 4) pad_sda_i[0] = 1'b1;
            if (!core_sda_i[0] && first == 0) first = k;
        end
        check_eq("glitch4_fall_edge", first, 6);
        check_eq("glitch4_other_ch", core_sda_i[1], 1'b1);
        tick(10);
        check_eq("glitch4_recovered", core_sda_i[0], 1'b1);

        // Stuck SCL on channel 1 with limit 100.
        timeout_lim = 16'd100;
        pad_scl_i[1] = 1'b0;
        first = 0;
        for (int k = 1; k <= 120; k++) begin
            tick(1);
            if (stuck_irq[1] && first == 0) first = k;
        end
        check_eq("stuck_rise_edge", first, 106);
        check_eq("stuck_ch0_quiet", stuck_irq[0], 1'b0);
        pad_scl_i[1] = 1'b1;
        tick(20);
        check_eq("stuck_sticky", stuck_irq[1], 1'b1);

        // Limit 0 disables detection.
        timeout_lim = '0;
        pad_scl_i[0] = 1'b0;
        seen_low = 0;
        for (int k = 0; k < 200; k++) begin
            tick(1);
            if (stuck_irq[0]) seen_low++;
        end
        check_eq("stuck_lim0", seen_low, 0);
        pad_scl_i[0] = 1'b1;
        tick(10);

        // Early-exit clear on channel 1: SDA freed during the third high phase.
        pad_sda_i[1] = 1'b0;
        tick(10);
        run_clear(1, 3, -1, pulses, busy_cyc, done_cyc, stop_lo, stop_scl, other, ok_end);
        check_eq("early_ended", ok_end, 1);
        check_eq("early_pulses", pulses, 3);
        check_eq("early_busy_cycles", busy_cyc, 3*16 + 3*8 + 1);
        check_eq("early_done_cycles", done_cyc, 1);
        check_eq("early_stop_low", stop_lo, 8);
        check_eq("early_stop_scl", stop_scl, 8);
        check_eq("early_other_busy", other, 0);
        check_eq("early_irq_cleared", stuck_irq[1], 1'b0);
        tick(5);

        // Full clear on channel 0: SDA held low throughout, second request ignored.
        pad_sda_i[0] = 1'b0;
        tick(10);
        run_clear(0, 0, 30, pulses, busy_cyc, done_cyc, stop_lo, stop_scl, other, ok_end);
        check_eq("full_ended", ok_end, 1);
        check_eq("full_pulses", pulses, 9);
        check_eq("full_busy_cycles", busy_cyc, 9*16 + 3*8 + 1);
        check_eq("full_done_cycles", done_cyc, 1);
        check_eq("full_stop_low", stop_lo, 8);
        check_eq("full_stop_scl", stop_scl, 8);
        check_eq("full_other_busy", other, 0);
        check_eq("full_core_resumes", pad_sda_oeb[0], 1'b0);
        core_sda_oen = '0; core_sda_o = '1;
        pad_sda_i[0] = 1'b1;
        tick(10);

        // Reset in the middle of PULSE_LOW.
        core_scl_oen = 2'b10; core_scl_o = 2'b00;
        clr_req[0] = 1'b1;
        tick(1);
        clr_req = '0;
        tick(2);
        check_eq("midrst_pre_oeb", pad_scl_oeb, 2'b00);
        rst = 1'b1;
        #1;
        check_eq("midrst_scl_oeb", pad_scl_oeb, 2'b11);
        check_eq("midrst_sda_oeb", pad_sda_oeb, 2'b11);
        check_eq("midrst_busy", clr_busy, 2'b00);
        check_eq("midrst_done", clr_done, 2'b00);
        tick(3);
        rst = 1'b0;
        dcount = 0; bcount = 0;
        for (int k = 0; k < 30; k++) begin
            tick(1);
            if (clr_done[0]) dcount++;
            if (clr_busy[0]) bcount++;
        end
        check_eq("midrst_no_done", dcount, 0);
        check_eq("midrst_no_busy", bcount, 0);
        check_eq("midrst_core_drive", pad_scl_oeb, 2'b01);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
